// File: rtl/counter_pkg.sv
// Shared types and constants for the count sequence checker.
package counter_pkg;

  typedef enum logic [1:0] {
    SEARCH  = 2'b00,
    ACQUIRE = 2'b01,
    LOCKED  = 2'b10
  } state_e;

  localparam int unsigned ERR_MAX = 255;
  localparam int unsigned ERR_W   = $clog2(ERR_MAX + 1);
  // Wide enough for the largest legal LOCK_CNT (15).
  localparam int unsigned GOOD_W  = 4;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at its all-ones value instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [WIDTH-1:0] value
);

  logic [WIDTH-1:0] value_q;
  logic [WIDTH-1:0] value_d;

  // NOTE: assign the default first so every path drives value_d and no latch is inferred.
  always_comb begin
    value_d = value_q;
    if (inc && (value_q != '1)) value_d = value_q + WIDTH'(1);
  end

  // NOTE: sequential state uses non-blocking assignment so all flops update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) value_q <= '0;
    else       value_q <= value_d;
  end

  assign value = value_q;

endmodule

// File: rtl/count_checker.sv
// Monitors a free-running counter and flags sequence errors once locked.
// Optional err_sticky output is enabled by defining COUNT_CHECKER_STICKY_EN.
module count_checker
  import counter_pkg::*;
#(
  parameter int WIDTH    = 5,
  parameter int LOCK_CNT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] count,
  output logic             locked,
  output logic             mismatch,
  output logic             wrap,
  output logic [ERR_W-1:0] err_count,
  output logic [WIDTH-1:0] expected
`ifdef COUNT_CHECKER_STICKY_EN
  ,
  output logic             err_sticky
`endif
);

  localparam logic [WIDTH-1:0]  CNT_MAX = '1;
  localparam logic [GOOD_W-1:0] LOCK_N  = GOOD_W'(LOCK_CNT);

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  prev_q, prev_d;
  logic [WIDTH-1:0]  expected_q, expected_d;
  logic [GOOD_W-1:0] good_q, good_d;
  logic              locked_q, locked_d;
  logic              mismatch_q, mismatch_d;
  logic              wrap_q, wrap_d;

  logic [WIDTH-1:0]  prev_inc;
  logic [GOOD_W-1:0] good_inc;
  logic              step_ok;
  logic              is_wrap;

  // Modular increment: the carry out of the top bit is intentionally dropped.
  assign prev_inc = prev_q + WIDTH'(1);
  assign step_ok  = (count == prev_inc);
  assign is_wrap  = (prev_q == CNT_MAX) && (count == '0);
  assign good_inc = (good_q == '1) ? good_q : good_q + GOOD_W'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= SEARCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (en) begin
      case (state_q)
        SEARCH:  state_d = ACQUIRE;
        ACQUIRE: if (step_ok && (good_inc >= LOCK_N)) state_d = LOCKED;
        LOCKED:  if (!step_ok) state_d = ACQUIRE;
        default: state_d = SEARCH;
      endcase
    end
  end

  always_comb begin
    prev_d     = prev_q;
    expected_d = expected_q;
    good_d     = good_q;
    mismatch_d = 1'b0;
    wrap_d     = 1'b0;
    if (en) begin
      prev_d     = count;
      expected_d = count + WIDTH'(1);
      case (state_q)
        ACQUIRE: good_d = step_ok ? good_inc : '0;
        LOCKED: begin
          if (!step_ok) begin
            mismatch_d = 1'b1;
            good_d     = '0;
          end else begin
            wrap_d = is_wrap;
          end
        end
        default: good_d = '0;
      endcase
    end
    locked_d = (state_d == LOCKED);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_q     <= '0;
      expected_q <= '0;
      good_q     <= '0;
      locked_q   <= 1'b0;
      mismatch_q <= 1'b0;
      wrap_q     <= 1'b0;
    end else begin
      prev_q     <= prev_d;
      expected_q <= expected_d;
      good_q     <= good_d;
      locked_q   <= locked_d;
      mismatch_q <= mismatch_d;
      wrap_q     <= wrap_d;
    end
  end

  sat_counter #(.WIDTH(ERR_W)) u_err_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (mismatch_d),
    .value (err_count)
  );

`ifdef COUNT_CHECKER_STICKY_EN
  logic err_sticky_q, err_sticky_d;

  assign err_sticky_d = err_sticky_q | mismatch_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) err_sticky_q <= 1'b0;
    else       err_sticky_q <= err_sticky_d;
  end

  assign err_sticky = err_sticky_q;
`endif

  assign locked   = locked_q;
  assign mismatch = mismatch_q;
  assign wrap     = wrap_q;
  assign expected = expected_q;

endmodule

// File: tb/tb_count_checker.sv
// Scoreboard bench for count_checker: directed samples push expected outputs,
// a monitor pops and compares them one clock edge later.
module tb_count_checker;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic [4:0] count;
  logic       locked;
  logic       mismatch;
  logic       wrap;
  logic [7:0] err_count;
  logic [4:0] expected;
`ifdef COUNT_CHECKER_STICKY_EN
  logic       err_sticky;
`endif

  always #5 clk = ~clk;

  count_checker #(.WIDTH(5), .LOCK_CNT(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .count     (count),
    .locked    (locked),
    .mismatch  (mismatch),
    .wrap      (wrap),
    .err_count (err_count),
    .expected  (expected)
`ifdef COUNT_CHECKER_STICKY_EN
    ,
    .err_sticky(err_sticky)
`endif
  );

  typedef struct {
    int         id;
    logic       lk;
    logic       mm;
    logic       wr;
    logic [7:0] err;
    logic [4:0] ex;
    logic       st;
  } exp_t;

  exp_t sb_q[$];

  int n_checks = 0;
  int n_errors = 0;
  int n_vec    = 0;

  logic [4:0] exp_exp    = '0;
  logic [7:0] exp_err    = '0;
  logic       exp_sticky = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Drive one sample on the falling edge and queue the outputs it must produce.
  task automatic step(input logic e, input logic [4:0] c,
                      input logic lk, input logic mm, input logic wr);
    exp_t it;
    @(negedge clk);
    en    = e;
    count = c;
    if (e) exp_exp = c + 5'd1;
    if (mm) begin
      exp_err    = (exp_err == 8'hFF) ? 8'hFF : exp_err + 8'd1;
      exp_sticky = 1'b1;
    end
    it.id  = n_vec;
    it.lk  = lk;
    it.mm  = mm;
    it.wr  = wr;
    it.err = exp_err;
    it.ex  = exp_exp;
    it.st  = exp_sticky;
    sb_q.push_back(it);
    n_vec++;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_locked"},   32'(locked),    32'd0);
    check({tag, "_mismatch"}, 32'(mismatch),  32'd0);
    check({tag, "_wrap"},     32'(wrap),      32'd0);
    check({tag, "_err"},      32'(err_count), 32'd0);
    check({tag, "_expected"}, 32'(expected),  32'd0);
`ifdef COUNT_CHECKER_STICKY_EN
    check({tag, "_sticky"},   32'(err_sticky), 32'd0);
`endif
  endtask

  task automatic do_reset(input int hold_ns);
    @(negedge clk);
    en    = 1'b0;
    reset = 1'b1;
    #1;
    check_all_zero("rst_immediate");
    #(hold_ns - 1);
    check_all_zero("rst_held");
    @(negedge clk);
    reset      = 1'b0;
    exp_exp    = '0;
    exp_err    = '0;
    exp_sticky = 1'b0;
  endtask

  // Monitor: outputs are registered, so they are valid just after the sampling edge.
  initial begin
    exp_t it;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        it = sb_q.pop_front();
        check($sformatf("v%0d_locked", it.id),   32'(locked),    32'(it.lk));
        check($sformatf("v%0d_mismatch", it.id), 32'(mismatch),  32'(it.mm));
        check($sformatf("v%0d_wrap", it.id),     32'(wrap),      32'(it.wr));
        check($sformatf("v%0d_err", it.id),      32'(err_count), 32'(it.err));
        check($sformatf("v%0d_expected", it.id), 32'(expected),  32'(it.ex));
`ifdef COUNT_CHECKER_STICKY_EN
        check($sformatf("v%0d_sticky", it.id),   32'(err_sticky), 32'(it.st));
`endif
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] cur;
    logic [4:0] bad;

    reset = 1'b1;
    en    = 1'b0;
    count = '0;
    #22;
    check_all_zero("rst_init");
    @(negedge clk);
    reset = 1'b0;

    // Acquire from 0: lock appears right after sample 4.
    for (int i = 0; i <= 5; i++) step(1'b1, 5'(i), (i >= 4), 1'b0, 1'b0);

    // Run through the top of the range: single wrap pulse after sample 0.
    for (int i = 6; i <= 31; i++) step(1'b1, 5'(i), 1'b1, 1'b0, 1'b0);
    step(1'b1, 5'd0, 1'b1, 1'b0, 1'b1);
    step(1'b1, 5'd1, 1'b1, 1'b0, 1'b0);

    // 7, 8, 12: mismatch while locked, then relock after four good steps.
    for (int i = 2; i <= 8; i++) step(1'b1, 5'(i), 1'b1, 1'b0, 1'b0);
    step(1'b1, 5'd12, 1'b0, 1'b1, 1'b0);
    step(1'b1, 5'd13, 1'b0, 1'b0, 1'b0);
    step(1'b1, 5'd14, 1'b0, 1'b0, 1'b0);
    step(1'b1, 5'd15, 1'b0, 1'b0, 1'b0);
    step(1'b1, 5'd16, 1'b1, 1'b0, 1'b0);

    // Enable low holds everything, even with a stray count value.
    step(1'b1, 5'd17, 1'b1, 1'b0, 1'b0);
    step(1'b0, 5'd17, 1'b1, 1'b0, 1'b0);
    step(1'b0, 5'd17, 1'b1, 1'b0, 1'b0);
    step(1'b0, 5'd3,  1'b1, 1'b0, 1'b0);
    step(1'b1, 5'd18, 1'b1, 1'b0, 1'b0);

    // Errors while acquiring are silent; wrap while acquiring gives no pulse.
    step(1'b1, 5'd25, 1'b0, 1'b1, 1'b0);
    step(1'b1, 5'd26, 1'b0, 1'b0, 1'b0);
    step(1'b1, 5'd30, 1'b0, 1'b0, 1'b0);
    step(1'b1, 5'd31, 1'b0, 1'b0, 1'b0);
    step(1'b1, 5'd0,  1'b0, 1'b0, 1'b0);
    step(1'b1, 5'd1,  1'b0, 1'b0, 1'b0);
    step(1'b1, 5'd2,  1'b1, 1'b0, 1'b0);

    // 300 locked mismatches, each followed by a relock; err_count sticks at 255.
    cur = 5'd2;
    for (int k = 0; k < 300; k++) begin
      bad = cur + 5'd5;
      step(1'b1, bad, 1'b0, 1'b1, 1'b0);
      for (int j = 1; j <= 4; j++) step(1'b1, bad + 5'(j), (j == 4), 1'b0, 1'b0);
      cur = bad + 5'd4;
    end

    // Reset right after a mismatch pulse clears it at once.
    step(1'b1, cur + 5'd9, 1'b0, 1'b1, 1'b0);
    do_reset(350);

    // First sample after reset is a plain search sample.
    step(1'b1, 5'd13, 1'b0, 1'b0, 1'b0);
    step(1'b1, 5'd14, 1'b0, 1'b0, 1'b0);
    step(1'b1, 5'd15, 1'b0, 1'b0, 1'b0);
    step(1'b1, 5'd16, 1'b0, 1'b0, 1'b0);
    step(1'b1, 5'd17, 1'b1, 1'b0, 1'b0);
    step(1'b1, 5'd9,  1'b0, 1'b1, 1'b0);

    @(negedge clk);
    en = 1'b0;
    for (int i = 0; i < 20 && sb_q.size() > 0; i++) @(posedge clk);
    #2;
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
